// File: rtl/z16_boot_pkg.sv
// Shared types and constants for the Z16 boot loader.
// The optional checksum stage (Z16_BOOT_CHECKSUM_EN) uses the CSUM state declared here.
package z16_boot_pkg;

  typedef enum logic [3:0] {
    MAGIC_LO,
    MAGIC_HI,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CSUM,
    DONE,
    ERR
  } boot_state_e;

  localparam logic [7:0] MAGIC_LO_BYTE     = 8'h16;
  localparam logic [7:0] MAGIC_HI_BYTE     = 8'h5A;
  localparam int         DEFAULT_MAX_WORDS = 256;

endpackage

// File: rtl/z16_boot_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave modport; the image source / memory side uses master.
interface z16_boot_if #(
  parameter int ADDR_W = 16
);

  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [15:0]       o_imem_wdata;
  logic              o_imem_wen;

  modport master (
    output i_byte, i_byte_valid,
    input  o_byte_ready, o_imem_addr, o_imem_wdata, o_imem_wen
  );

  modport slave (
    input  i_byte, i_byte_valid,
    output o_byte_ready, o_imem_addr, o_imem_wdata, o_imem_wen
  );

endinterface

// File: rtl/z16_boot_csum.sv
// 8-bit modulo-256 running sum of payload bytes with a compare against a received byte.
// Instantiated by z16_boot_loader only when Z16_BOOT_CHECKSUM_EN is defined.
module z16_boot_csum (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] byte_i,
  input  logic [7:0] cmp_i,
  output logic       match_o
);

  logic [7:0] sum_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || clr_i) begin
      sum_q <= '0;
    end else if (add_i) begin
      sum_q <= sum_q + byte_i;
    end
  end

  assign match_o = (cmp_i == sum_q);

endmodule

// File: rtl/z16_boot_loader.sv
// Framed byte-stream loader that writes little-endian 16-bit words into Z16 instruction
// memory and holds the CPU in reset until done. Define Z16_BOOT_CHECKSUM_EN for the trailing checksum byte.
module z16_boot_loader
  import z16_boot_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter logic [15:0] MAGIC     = {MAGIC_HI_BYTE, MAGIC_LO_BYTE}
) (
  input  logic     i_clk,
  input  logic     i_rst,
  z16_boot_if.slave bus,
  output logic     o_cpu_rst,
  output logic     o_done,
  output logic     o_err
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  boot_state_e       state_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [15:0]       word_idx_q;
  logic [7:0]        lo_byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              wen_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;

  logic              byte_acc;
  logic [15:0]       len_in;
  logic              len_bad;
  logic              last_word;
  logic [ADDR_W-1:0] word_addr;

  assign bus.o_byte_ready = (state_q != DONE) && (state_q != ERR);
  assign byte_acc         = bus.i_byte_valid && bus.o_byte_ready;
  assign len_in           = {bus.i_byte, len_lo_q};
  assign len_bad          = (len_in == 16'd0) || ({1'b0, len_in} > MAX_LEN);
  assign last_word        = ((word_idx_q + 16'd1) == len_q);
  // Byte address of a word wraps modulo 2^ADDR_W.
  assign word_addr        = ADDR_W'({word_idx_q, 1'b0});

`ifdef Z16_BOOT_CHECKSUM_EN
  logic csum_match;

  z16_boot_csum u_csum (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clr_i   (byte_acc && (state_q == LEN_HI)),
    .add_i   (byte_acc && ((state_q == DATA_LO) || (state_q == DATA_HI))),
    .byte_i  (bus.i_byte),
    .cmp_i   (bus.i_byte),
    .match_o (csum_match)
  );
`endif

  // NOTE: every register here uses non-blocking assignment and a synchronous reset branch,
  // so all state (including cpu_rst) updates together on the clock edge that samples i_rst.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= MAGIC_LO;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      lo_byte_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      // Release lags entry into DONE so the last write always lands before the CPU runs.
      if (state_q == DONE) begin
        done_q    <= 1'b1;
        cpu_rst_q <= 1'b0;
      end
      if (byte_acc) begin
        case (state_q)
          MAGIC_LO: begin
            if (bus.i_byte == MAGIC[7:0]) state_q <= MAGIC_HI;
          end
          MAGIC_HI: begin
            if (bus.i_byte == MAGIC[15:8])     state_q <= LEN_LO;
            else if (bus.i_byte != MAGIC[7:0]) state_q <= MAGIC_LO;
          end
          LEN_LO: begin
            len_lo_q <= bus.i_byte;
            state_q  <= LEN_HI;
          end
          LEN_HI: begin
            len_q      <= len_in;
            word_idx_q <= '0;
            if (len_bad) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA_LO;
            end
          end
          DATA_LO: begin
            lo_byte_q <= bus.i_byte;
            state_q   <= DATA_HI;
          end
          DATA_HI: begin
            wdata_q    <= {bus.i_byte, lo_byte_q};
            addr_q     <= word_addr;
            wen_q      <= 1'b1;
            word_idx_q <= word_idx_q + 16'd1;
            if (last_word) begin
`ifdef Z16_BOOT_CHECKSUM_EN
              state_q <= CSUM;
`else
              state_q <= DONE;
`endif
            end else begin
              state_q <= DATA_LO;
            end
          end
`ifdef Z16_BOOT_CHECKSUM_EN
          CSUM: begin
            if (csum_match) begin
              state_q <= DONE;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_wdata = wdata_q;
  assign bus.o_imem_wen   = wen_q;
  assign o_cpu_rst        = cpu_rst_q;
  assign o_done           = done_q;
  assign o_err            = err_q;

endmodule

// File: doc/z16_boot_loader.md
Name: z16_boot_loader

Overview:
- Byte-stream image loader that fills Z16 instruction memory before the CPU runs.
- It is the writer side of the instruction memory: the CPU only fetches 16-bit words at even byte addresses, and this block writes them.
- Receives a framed image over a valid/ready byte interface, assembles little-endian 16-bit words, and issues one write per word.
- Holds the CPU in reset until the image is complete and valid.

Parameters:
- ADDR_W, 16, byte-address width of the instruction memory write port.
- MAX_WORDS, 256, largest accepted image length in 16-bit words.
- MAGIC, 16'h5A16, frame start marker; sent low byte first.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_byte  in  8  incoming image byte.
- i_byte_valid  in  1  i_byte is valid this cycle.
- o_byte_ready  out  1  loader accepts a byte this cycle.
- o_imem_addr  out  ADDR_W  byte address of the instruction write.
- o_imem_wdata  out  16  instruction word to write.
- o_imem_wen  out  1  one-cycle write strobe.
- o_cpu_rst  out  1  reset for the Z16 CPU; high while loading.
- o_done  out  1  image loaded; sticky until i_rst.
- o_err  out  1  frame error; sticky until i_rst.

Behaviour:
- Clock and reset: one clock i_clk. Reset i_rst is synchronous and active-high; all state updates happen on the posedge of i_clk.
- Reset values:
  - FSM in MAGIC_LO.
  - o_imem_addr=0, o_imem_wdata=0, o_imem_wen=0.
  - o_cpu_rst=1, o_done=0, o_err=0.
  - Word counter=0, length=0, checksum=0.
- Byte transfer: a byte is accepted on a posedge where i_byte_valid & o_byte_ready.
  - o_byte_ready=1 in MAGIC_LO, MAGIC_HI, LEN_LO, LEN_HI, DATA_LO, DATA_HI and CSUM.
  - o_byte_ready=0 in DONE and ERR.
  - One byte per cycle is sustainable; there is no backpressure during loading.
- Frame format: magic (0x16, 0x5A), then length in words (LSB, MSB), then length×(LSB, MSB) payload, then checksum byte (macro only).
- State transitions (on accepted byte):
  - MAGIC_LO: 0x16 goes to MAGIC_HI; any other byte stays in MAGIC_LO (resync hunting).
  - MAGIC_HI: 0x5A goes to LEN_LO; 0x16 stays in MAGIC_HI; anything else returns to MAGIC_LO.
  - LEN_LO to LEN_HI.
  - LEN_HI: a 16-bit length of 0 or greater than MAX_WORDS goes to ERR; otherwise goes to DATA_LO.
  - DATA_LO: latches the low byte, goes to DATA_HI.
  - DATA_HI: on the same edge, registers o_imem_wdata={byte, low}, o_imem_addr=2×word_index, o_imem_wen=1, and increments word_index.
    - If this was the last word: goes to CSUM when the macro is defined, otherwise to DONE.
    - Otherwise: returns to DATA_LO.
- Write strobe: o_imem_wen is high for exactly one cycle per word. Addresses are 0, 2, 4, …, matching the CPU's PC+2 stepping. Address arithmetic is modulo 2^ADDR_W.
- Completion: the cycle after entering DONE, o_cpu_rst=0 and o_done=1.
  - The last write strobe therefore always precedes CPU release by one cycle.
- Error: in ERR, o_err=1 and o_cpu_rst stays 1.
- Reset mid-frame: i_rst in any state restores the reset values. Partially written memory is not cleared; o_cpu_rst is reasserted immediately.
- Stuck states: DONE and ERR ignore i_byte_valid; only i_rst leaves them.

Optional Feature:
- Macro Z16_BOOT_CHECKSUM_EN.
- When defined:
  - Every accepted payload byte is added into an 8-bit running sum, modulo 256.
  - After the last payload word the FSM enters CSUM.
  - In CSUM, a byte equal to the sum goes to DONE; any other byte goes to ERR.
  - Words are already written before this check; ERR keeps the CPU in reset.
- When undefined: no CSUM state and no sum register; the last DATA_HI goes directly to DONE.

Decomposition:
- Package z16_boot_pkg holds:
  - the state enum (MAGIC_LO, MAGIC_HI, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, DONE, ERR);
  - MAGIC_LO_BYTE=8'h16 and MAGIC_HI_BYTE=8'h5A;
  - the default MAX_WORDS.
- One sub-module: z16_boot_csum, an 8-bit accumulator with clear/add/compare. It is instantiated only under Z16_BOOT_CHECKSUM_EN.
- Word assembly and addressing stay in the top module.

Test Plan:
- Basic load: send 16 5A 02 00 34 12 78 56 back-to-back. Expect writes (addr 0, 0x1234) then (addr 2, 0x5678), then o_cpu_rst=0 and o_done=1 one cycle after the second strobe.
- Resync: send 00 16 16 5A 01 00 CD AB. Garbage is ignored and there is a single write (0, 0xABCD), then done.
- Length errors: send length 0x0000, or length 0x0101 with MAX_WORDS=256. Expect o_err=1, no writes, and o_cpu_rst held at 1 indefinitely.
- Gapped valid: send the basic-load frame with i_byte_valid toggling 1,0,1,0. Expect the same writes and addresses; o_imem_wen is never high for two consecutive cycles.
- Mid-frame reset: pulse i_rst after the first payload byte, then send a fresh frame. Expect addresses restart at 0, with o_cpu_rst high throughout until the new done.
- Checksum (macro on): send frame 16 5A 01 00 10 20 followed by 30, which gives DONE. Send the same frame followed by 31, which gives o_err=1 after the write of 0x2010 to addr 0.
